// File: rtl/hexfmt_tx.sv
// hexfmt_tx: queues DATA_W-bit words and streams them as ASCII hex bytes to a txuart.
// Define HEXFMT_PREFIX_EN to start every word with "0x".
module hexfmt_tx #(
  parameter int DATA_W  = 32,
  parameter int FIFO_LG = 2,
  parameter int LOWER   = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_stb,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_eol,
  output logic              o_full,
  output logic              o_overflow,
  output logic              o_busy,
  output logic              o_tx_stb,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_busy
);

  localparam int ND    = DATA_W / 4;
  localparam int DEPTH = 1 << FIFO_LG;
  localparam int CW    = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [FIFO_LG:0] FULL_CNT = (FIFO_LG + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef HEXFMT_PREFIX_EN
    S_PFX0,
    S_PFXX,
`endif
    S_DIG,
    S_SEP,
    S_CR,
    S_LF
  } state_t;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return ((LOWER != 0) ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
  endfunction

  // ---------------- word FIFO: {eol, data} ----------------
  logic [DATA_W:0]    mem [DEPTH];
  logic [FIFO_LG-1:0] wr_ptr, rd_ptr;
  logic [FIFO_LG:0]   count;
  logic               fifo_empty, push, pop;

  state_t            state, state_d;
  logic [DATA_W-1:0] sh, sh_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic              eol_q, eol_d;
  logic [7:0]        tx_data_d;
  logic              accept;

  assign fifo_empty = (count == '0);
  assign o_full     = (count == FULL_CNT);
  assign push       = i_stb && !o_full;
  assign pop        = (state == S_IDLE) && !fifo_empty;

  // NOTE: storage only; validity is tracked by count, so the array needs no reset.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_eol, i_data};
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (i_stb && o_full) o_overflow <= 1'b1;
    end
  end

  // ---------------- formatter ----------------
  assign o_tx_stb = (state != S_IDLE);
  assign o_busy   = !fifo_empty || (state != S_IDLE);
  assign accept   = o_tx_stb && !i_tx_busy;

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    state_d = state;
    sh_d    = sh;
    cnt_d   = cnt;
    eol_d   = eol_q;
    case (state)
      S_IDLE: if (!fifo_empty) begin
        {eol_d, sh_d} = mem[rd_ptr];
        cnt_d         = CW'(ND - 1);
`ifdef HEXFMT_PREFIX_EN
        state_d       = S_PFX0;
`else
        state_d       = S_DIG;
`endif
      end
`ifdef HEXFMT_PREFIX_EN
      S_PFX0: if (accept) state_d = S_PFXX;
      S_PFXX: if (accept) state_d = S_DIG;
`endif
      S_DIG: if (accept) begin
        sh_d  = sh << 4;
        cnt_d = cnt - 1'b1;
        if (cnt == '0) state_d = eol_q ? S_CR : S_SEP;
      end
      S_SEP:   if (accept) state_d = S_IDLE;
      S_CR:    if (accept) state_d = S_LF;
      S_LF:    if (accept) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The byte for the upcoming state is registered so it is valid with o_tx_stb;
  // during a stall state_d/sh_d equal the current values, holding the byte steady.
  always_comb begin
    tx_data_d = 8'h00;
    case (state_d)
`ifdef HEXFMT_PREFIX_EN
      S_PFX0:  tx_data_d = 8'h30;
      S_PFXX:  tx_data_d = 8'h78;
`endif
      S_DIG:   tx_data_d = hex_char(sh_d[DATA_W-1 -: 4]);
      S_SEP:   tx_data_d = 8'h20;
      S_CR:    tx_data_d = 8'h0D;
      S_LF:    tx_data_d = 8'h0A;
      default: tx_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      sh        <= '0;
      cnt       <= '0;
      eol_q     <= 1'b0;
      o_tx_data <= 8'h00;
    end else begin
      state     <= state_d;
      sh        <= sh_d;
      cnt       <= cnt_d;
      eol_q     <= eol_d;
      o_tx_data <= tx_data_d;
    end
  end

endmodule

// File: doc/hexfmt_tx.md
# hexfmt_tx

Parametrised hex-formatting byte source for the UART debug path. It queues words of configurable width in a small FIFO and renders each word as ASCII hex: optional `0x` prefix, then the digits MSB-first, then a space or a CRLF chosen per word. It drives an existing `txuart` instance in the parent through that instance's `i_wr`/`i_data`/`o_busy` handshake.

## Interface
Parameters:
- `DATA_W`, 32: word width in bits; a multiple of 4, range 4..64; digits per word `ND = DATA_W/4`.
- `FIFO_LG`, 2: FIFO depth is `2**FIFO_LG` words.
- `LOWER`, 0: when 1, digits a–f are lowercase; when 0, A–F.

Ports:
- `i_clk` input 1: the single clock.
- `i_reset` input 1: synchronous, active-high reset.
- `i_stb` input 1: push request for one word.
- `i_data` input DATA_W: word to format.
- `i_eol` input 1: 1 = end this word with CR LF; 0 = end it with a space (0x20).
- `o_full` output 1: FIFO full; a push is refused.
- `o_overflow` output 1: sticky; set when a push is refused.
- `o_busy` output 1: FIFO non-empty or formatter not IDLE.
- `o_tx_stb` output 1: byte valid; connects to `txuart.i_wr`.
- `o_tx_data` output 8: ASCII byte; connects to `txuart.i_data`.
- `i_tx_busy` input 1: from `txuart.o_busy`.

## Operation
- **Push:** when `i_stb && !o_full`, write `{i_eol, i_data}` to the FIFO. If `i_stb && o_full`, drop the word and set `o_overflow`. `o_full` comes from the registered count, so a push is refused when the FIFO is full even if a pop happens in the same cycle.
- **States:** IDLE, PFX0, PFXX, DIG, SEP, CR, LF.
- **IDLE:** if the FIFO is non-empty, pop into the word shift register, load the digit counter with `ND-1`, and go to PFX0 (or to DIG without the prefix feature).
- **Advance rule:** a byte is accepted in any cycle where `o_tx_stb && !i_tx_busy`. The state advances only on acceptance.
- **Bytes per state:**
  - PFX0 sends "0", then goes to PFXX.
  - PFXX sends "x", then goes to DIG.
  - DIG sends the hex of the top nibble. On acceptance, shift left 4 and decrement the counter; after the digit at count 0, go to CR if the stored eol is 1, otherwise to SEP.
  - SEP sends 0x20, then goes to IDLE.
  - CR sends 0x0D, then goes to LF.
  - LF sends 0x0A, then goes to IDLE.
- `o_tx_stb` is high in every state except IDLE.
- `o_tx_data` is registered and valid in the same cycle `o_tx_stb` is high. It stays stable while `o_tx_stb && i_tx_busy`.
- **Consumer requirement:** `i_tx_busy` is high in the cycle after an acceptance.
- **Reset values:** all outputs 0 (`o_tx_data` = 8'h00); FIFO empty; state IDLE.
- **Reset mid-word:** the rest of the word is abandoned and queued words are discarded. Any byte `txuart` has already taken completes inside `txuart`.

## Timing
- **Latency, idle block:** `i_stb` sampled at edge N → FIFO non-empty after N → pop at edge N+1 → `o_tx_stb` high after edge N+1.
- **Within a word:** with `i_tx_busy` low, the next byte is presented the cycle after acceptance. `o_tx_stb` stays high with no gaps.
- **Between words:** `o_tx_stb` is low for exactly one cycle (the IDLE cycle) after the last byte of a word is accepted.
- **Bytes per word:** `ND + 1` with space ending, or `ND + 2` with CRLF ending, plus 2 when the prefix feature is compiled in.
- **`o_busy`:** falls the cycle after the last byte is accepted, provided the FIFO is empty.

## Configuration
- `HEXFMT_PREFIX_EN` defined: every word starts with "0x" (states PFX0 and PFXX present).
- Not defined: PFX0 and PFXX are removed and IDLE pops directly into DIG.

## Test plan
- **Prefix, CRLF:** `HEXFMT_PREFIX_EN` defined, `DATA_W`=32, `i_tx_busy` held 0, push 32'hDEADBEEF with eol=1 → 12 consecutive accepted bytes "0xDEADBEEF\r\n"; then `o_busy`=0.
- **No prefix, lowercase, mixed endings:** macro undefined, `DATA_W`=16, `LOWER`=1, push 16'hA05F eol=0 and 16'h0001 eol=1 back-to-back → "a05f 0001\r\n", with a single-cycle `o_tx_stb` gap between words.
- **Back-pressure:** model `txuart` busy for 10 cycles after each accept → each byte accepted exactly once; `o_tx_data` never changes while `o_tx_stb && i_tx_busy`.
- **Overflow:** `FIFO_LG`=2, `i_tx_busy` held 1, push 6 words → 5 accepted (1 popped into the formatter plus 4 queued), `o_full`=1, 6th dropped, `o_overflow`=1. After releasing busy, exactly 5 words are printed in order.
- **Reset mid-word:** assert `i_reset` after 3 bytes of 32'h12345678 with 2 words queued → next cycle `o_tx_stb`=0, `o_busy`=0, `o_overflow`=0. A new push of 32'h0000000F prints from its first byte.
- **Full with simultaneous pop:** FIFO full, pop and push in the same cycle → push refused, `o_overflow` set, count decrements by 1.
